bit_shift_collector: RTL and testbench
======================================

// Module: bit_shift_collector
// PURPOSE
//  Receiving end of the bit-serial datapath: collects an LSB-first serial stream (one bit per
//  enabled clock, as produced by the bit-serial adder a_i output) into a DATA_WIDTH-bit word.
//  Holds the word with a valid/ready handshake for the next pipeline stage (modular reduce / mult).
//  Sits directly after the serial adder in the RSA datapath; started in step with its load.
// PARAMETERS
//  DATA_WIDTH  1025                        word width = number of serial bits collected
//  CNT_WIDTH   $clog2(DATA_WIDTH+1)        bit-counter width (derived, do not override)
// PORTS
//  clk    in   1           clock, all state updates on posedge
//  rst    in   1           synchronous, active-high reset
//  ce     in   1           clock enable; ce=0 freezes all state (outputs hold)
//  start  in   1           clear collector and arm for a new word
//  en     in   1           a_i carries a valid bit this cycle
//  a_i    in   1           serial data bit, LSB first
//  m      in   DATA_WIDTH  compare operand, sampled on start (only with BSC_CMP_EN)
//  ready  in   1           downstream accepts data this cycle
//  busy   out  1           collecting (state COLLECT)
//  valid  out  1           data holds a complete word (state HOLD)
//  data   out  DATA_WIDTH  collected word; bit k = k-th accepted serial bit
//  err    out  1           sticky: en seen outside COLLECT
//  ge     out  1           data >= m, valid with valid (only with BSC_CMP_EN)
// BEHAVIOUR
//  - Reset (rst=1 at posedge, overrides ce): state IDLE, shreg=0, cnt=0, err=0, ge=1;
//    busy=0, valid=0, data=0.
//  - All updates below occur only when ce=1.
//  - FSM IDLE/COLLECT/HOLD. start has priority in every state: shreg<=0, cnt<=0, err<=0,
//    state<=COLLECT; any en in the same cycle is ignored and does not set err.
//  - COLLECT, en=1: shreg <= {a_i, shreg[W-1:1]}, cnt<=cnt+1. On the W-th accepted bit
//    (cnt==W-1 && en) state<=HOLD. en=0: hold. Gaps between bits allowed, any length.
//  - Latency: start at edge t -> first bit accepted at edge t+1 earliest; valid=1 in the
//    cycle following the edge that accepts the W-th bit. Back-to-back en: W+1 cycles after start.
//  - HOLD: valid=1, data stable. valid&&ready -> IDLE (valid=0 next cycle, data retained).
//    ready while not valid is ignored. start && ready in HOLD: transfer completes, and the
//    start is also taken -> COLLECT.
//  - en=1 in IDLE or HOLD (no start): bit dropped, data unchanged, err<=1 (sticky until
//    start/rst).
//  - cnt never exceeds W; no wrap-around: extra bits only raise err.
//  - Reset mid-collection discards the partial word; no output pulses.
//  - busy = (state==COLLECT), valid = (state==HOLD), data = shreg (registered, no combo path
//    from a_i).
// CONFIGURATION
//  BSC_CMP_EN defined: on start, m is latched into an internal register and ge<=1.
//    Per accepted bit k: ge <= (a_i & ~m_k) | (~(a_i ^ m_k) & ge), giving LSB-first serial
//    compare. In HOLD, ge = (data >= m) and is held.
//    Lets the reduction stage skip a subtraction cycle.
//  BSC_CMP_EN undefined: m port and ge output absent, no m register; all other behaviour
//    identical.
// TESTING  (bench uses DATA_WIDTH=8)
//  1. rst, then start; en=1 for 8 cycles, a_i = bits of 0xA5 LSB first -> valid=1 the next
//     cycle, data=0xA5, busy=0, err=0.
//  2. Same word with en gaps (1,0,0,1,...), ready=0 for 5 cycles in HOLD -> data=0xA5 stable,
//     valid held; ready=1 -> valid=0 next cycle.
//  3. en=1 in IDLE, and again in HOLD -> err=1, data unchanged; next start -> err=0.
//  4. start after 4 of 8 bits, then 8 bits of 0x3C -> data=0x3C (partial word discarded);
//     rst after 3 bits -> all outputs at reset values.
//  5. In HOLD, start && ready in the same cycle -> one transfer, busy=1 next cycle;
//     ce=0 mid-word for 3 cycles with en=1 -> no bits accepted.
//  6. [BSC_CMP_EN] m=0x80: word 0x80 -> ge=1; word 0x7F -> ge=0; word 0xFF -> ge=1;
//     m=0x00, word 0x00 -> ge=1.

Source files
------------

// File: rtl/bit_shift_collector_if.sv
// Handshake bundle between the bit-serial adder output and the collector (slave side is the collector).
// Optional compare signals m/ge exist only when BSC_CMP_EN is defined.
interface bit_shift_collector_if #(
    parameter int DATA_WIDTH = 1025
);
    logic                  ce;
    logic                  start;
    logic                  en;
    logic                  a_i;
    logic                  ready;
    logic                  busy;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
`ifdef BSC_CMP_EN
    logic [DATA_WIDTH-1:0] m;
    logic                  ge;
`endif

    modport master (
        output ce, start, en, a_i, ready,
        input  busy, valid, data, err
`ifdef BSC_CMP_EN
        , output m
        , input  ge
`endif
    );

    modport slave (
        input  ce, start, en, a_i, ready,
        output busy, valid, data, err
`ifdef BSC_CMP_EN
        , input  m
        , output ge
`endif
    );
endinterface

// File: rtl/bit_shift_collector.sv
// Collects an LSB-first serial stream into a DATA_WIDTH-bit word and offers it with valid/ready.
// Define BSC_CMP_EN to add a bit-serial (data >= m) compare that is ready together with valid.
module bit_shift_collector #(
    parameter int DATA_WIDTH = 1025,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    bit_shift_collector_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic [DATA_WIDTH-1:0] shreg_shifted;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  err_reg, err_next;

`ifdef BSC_CMP_EN
    // The operand shifts right alongside the data so bit k of m is always at m_reg[0].
    logic [DATA_WIDTH-1:0] m_reg, m_next;
    logic [DATA_WIDTH-1:0] m_shifted;
    logic                  ge_reg, ge_next;
    logic                  ge_bit;
`endif

    // New bits enter at the MSB end so that after W shifts bit k sits at position k.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            if (gi == DATA_WIDTH - 1) begin : g_top
                assign shreg_shifted[gi] = bus.a_i;
`ifdef BSC_CMP_EN
                assign m_shifted[gi]     = 1'b0;
`endif
            end else begin : g_body
                assign shreg_shifted[gi] = shreg_reg[gi + 1];
`ifdef BSC_CMP_EN
                assign m_shifted[gi]     = m_reg[gi + 1];
`endif
            end
        end
    endgenerate

`ifdef BSC_CMP_EN
    // A higher-order differing bit overrides; equal bits keep the lower-order verdict.
    assign ge_bit = (bus.a_i & ~m_reg[0]) | (~(bus.a_i ^ m_reg[0]) & ge_reg);
`endif

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`ifdef BSC_CMP_EN
        m_next     = m_reg;
        ge_next    = ge_reg;
`endif
        if (bus.ce) begin
            if (bus.start) begin
                // start wins in every state; a simultaneous en is neither taken nor flagged.
                state_next = ST_COLLECT;
                shreg_next = '0;
                cnt_next   = '0;
                err_next   = 1'b0;
`ifdef BSC_CMP_EN
                m_next     = bus.m;
                ge_next    = 1'b1;
`endif
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.en) begin
                            err_next = 1'b1;
                        end
                    end
                    ST_COLLECT: begin
                        if (bus.en) begin
                            shreg_next = shreg_shifted;
                            cnt_next   = cnt_reg + CNT_ONE;
`ifdef BSC_CMP_EN
                            m_next     = m_shifted;
                            ge_next    = ge_bit;
`endif
                            if (cnt_reg == CNT_LAST) begin
                                state_next = ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.en) begin
                            err_next = 1'b1;
                        end
                        if (bus.ready) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`ifdef BSC_CMP_EN
            m_reg     <= '0;
            ge_reg    <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`ifdef BSC_CMP_EN
            m_reg     <= m_next;
            ge_reg    <= ge_next;
`endif
        end
    end

    assign bus.busy  = (state_reg == ST_COLLECT);
    assign bus.valid = (state_reg == ST_HOLD);
    assign bus.data  = shreg_reg;
    assign bus.err   = err_reg;
`ifdef BSC_CMP_EN
    assign bus.ge    = ge_reg;
`endif

endmodule

// File: tb/tb_bit_shift_collector.sv
// Scoreboarded bench for bit_shift_collector at DATA_WIDTH=8; compare tests need BSC_CMP_EN.
module tb_bit_shift_collector;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         ge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic valid_q = 1'b0;

    bit_shift_collector_if #(.DATA_WIDTH(W)) bus ();

    bit_shift_collector #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every rising valid is one delivered word, matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            if (bus.valid && !valid_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h required none", bus.data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", bus.data, mon_e.data);
`ifdef BSC_CMP_EN
                    check("word_ge", W'(bus.ge), W'(mon_e.ge));
`endif
                    $display("word data=%0h expected=%0h", bus.data, mon_e.data);
                end
            end
            valid_q <= bus.valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] mv);
        bus.start = 1'b1;
`ifdef BSC_CMP_EN
        bus.m = mv;
`else
        if (mv != '0) $display("note: m=%0h unused in this build", mv);
`endif
        tick();
        bus.start = 1'b0;
    endtask

    // Sends bits first..last of w; with gap set, bit i is followed by i%3 idle cycles.
    task automatic send_bits(input logic [W-1:0] w, input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            bus.en  = 1'b1;
            bus.a_i = w[i];
            tick();
            bus.en  = 1'b0;
            if (gap) begin
                for (int g = 0; g < i % 3; g++) tick();
            end
        end
    endtask

    task automatic word(input logic [W-1:0] mv, input logic [W-1:0] w,
                        input logic ge_exp, input bit gap);
        exp_t e;
        e.data = w;
        e.ge   = ge_exp;
        exp_q.push_back(e);
        do_start(mv);
        send_bits(w, 0, W - 1, gap);
        check("valid_after_word", W'(bus.valid), 1);
    endtask

    task automatic release_word();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        check("valid_after_ready", W'(bus.valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.ce    = 1'b1;
        bus.start = 1'b0;
        bus.en    = 1'b0;
        bus.a_i   = 1'b0;
        bus.ready = 1'b0;
`ifdef BSC_CMP_EN
        bus.m     = '0;
`endif
        tick();
        tick();
        check("rst_busy", W'(bus.busy), 0);
        check("rst_valid", W'(bus.valid), 0);
        check("rst_data", bus.data, 8'h00);
        check("rst_err", W'(bus.err), 0);
`ifdef BSC_CMP_EN
        check("rst_ge", W'(bus.ge), 1);
`endif
        rst = 1'b0;
        tick();

        // 1: back-to-back bits of 0xA5
        exp_q.push_back('{data: 8'hA5, ge: 1'b1});
        do_start(8'h00);
        check("busy_after_start", W'(bus.busy), 1);
        send_bits(8'hA5, 0, W - 1, 1'b0);
        check("t1_valid", W'(bus.valid), 1);
        check("t1_busy", W'(bus.busy), 0);
        check("t1_err", W'(bus.err), 0);
        check("t1_data", bus.data, 8'hA5);
        release_word();

        // 2: gapped bits, HOLD under back-pressure
        word(8'h00, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", W'(bus.valid), 1);
            check("t2_hold_data", bus.data, 8'hA5);
        end
        release_word();
        check("t2_data_retained", bus.data, 8'hA5);

        // 3: stray en in IDLE and in HOLD
        bus.en  = 1'b1;
        bus.a_i = 1'b1;
        tick();
        bus.en  = 1'b0;
        check("t3_idle_err", W'(bus.err), 1);
        check("t3_idle_data", bus.data, 8'hA5);
        check("t3_idle_valid", W'(bus.valid), 0);
        word(8'h00, 8'h5A, 1'b1, 1'b0);
        check("t3_err_cleared", W'(bus.err), 0);
        bus.en  = 1'b1;
        bus.a_i = 1'b1;
        tick();
        bus.en  = 1'b0;
        check("t3_hold_err", W'(bus.err), 1);
        check("t3_hold_data", bus.data, 8'h5A);
        check("t3_hold_valid", W'(bus.valid), 1);
        release_word();

        // 4: restart mid-word, then reset mid-word
        do_start(8'h00);
        check("t4_err_cleared", W'(bus.err), 0);
        send_bits(8'hFF, 0, 3, 1'b0);
        word(8'h00, 8'h3C, 1'b1, 1'b0);
        check("t4_data", bus.data, 8'h3C);
        release_word();
        do_start(8'h00);
        send_bits(8'hFF, 0, 2, 1'b0);
        rst = 1'b1;
        tick();
        check("t4_rst_busy", W'(bus.busy), 0);
        check("t4_rst_valid", W'(bus.valid), 0);
        check("t4_rst_data", bus.data, 8'h00);
        check("t4_rst_err", W'(bus.err), 0);
        rst = 1'b0;
        tick();

        // 5: start && ready in HOLD, then ce=0 with en=1 mid-word
        word(8'h00, 8'h96, 1'b1, 1'b0);
        exp_q.push_back('{data: 8'hC3, ge: 1'b1});
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ready = 1'b0;
        check("t5_valid_dropped", W'(bus.valid), 0);
        check("t5_busy", W'(bus.busy), 1);
        send_bits(8'hC3, 0, 2, 1'b0);
        bus.ce  = 1'b0;
        bus.en  = 1'b1;
        bus.a_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_ce_busy", W'(bus.busy), 1);
        end
        bus.ce = 1'b1;
        bus.en = 1'b0;
        send_bits(8'hC3, 3, W - 1, 1'b0);
        check("t5_valid", W'(bus.valid), 1);
        check("t5_data", bus.data, 8'hC3);
        release_word();

`ifdef BSC_CMP_EN
        // 6: serial compare against m
        word(8'h80, 8'h80, 1'b1, 1'b0);
        check("t6_ge_eq", W'(bus.ge), 1);
        release_word();
        word(8'h80, 8'h7F, 1'b0, 1'b0);
        check("t6_ge_lt", W'(bus.ge), 0);
        release_word();
        word(8'h80, 8'hFF, 1'b1, 1'b1);
        check("t6_ge_gt", W'(bus.ge), 1);
        release_word();
        word(8'h00, 8'h00, 1'b1, 1'b0);
        check("t6_ge_zero", W'(bus.ge), 1);
        release_word();
`endif

        tick();
        tick();
        check("queue_drained", W'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
